store_buffer: RTL
=================

# store_buffer

Four-entry store buffer sitting between the EX/MEM pipeline register and `dataMemory`. Stores from the MEM stage retire into the buffer in one cycle and drain to `dataMemory` whenever its port is not needed by a load. Loads get priority on the port, with word forwarding from buffered stores. The block stalls the pipeline on partial-overlap hazards. It owns every `dataMemory` control input: `memWrite`, `memRead`, `sByte`, `addr` and `wrData`.

## Interface
- `DEPTH`, 4: number of buffer entries; must be a power of two, 2 or greater.
- `AW`, 16: address width.
- `DW`, 16: data width.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `st_valid`  in  1  MEM stage presents a store.
- `st_addr`  in  AW  store byte address.
- `st_data`  in  DW  store data; byte stores use `[7:0]` only.
- `st_byte`  in  1  store is a byte store.
- `st_ready`  out  1  buffer can accept a store this cycle; equals `!full`.
- `ld_valid`  in  1  MEM stage presents a load.
- `ld_addr`  in  AW  load byte address.
- `ld_byte`  in  1  load is a byte load.
- `ld_data`  out  DW  load result; valid when `ld_valid && !ld_stall`.
- `ld_stall`  out  1  load cannot complete this cycle; the pipeline holds MEM.
- `mem_rdata`  in  DW  `dataOut` from `dataMemory` (combinational read).
- `memWrite`, `memRead`, `sByte`  out  1 each  `dataMemory` controls.
- `addr`  out  AW  `dataMemory` address.
- `wrData`  out  DW  `dataMemory` write data.
- `empty`  out  1  no buffered stores; used by halt logic.
- `count`  out  log2(DEPTH)+1  occupancy.

## Operation
- **Storage:** circular FIFO with `head`, `tail` and `count` registers. Each entry holds {addr, data, byte}.
- **Push:** when `st_valid && st_ready`, write the entry at `tail` and advance `tail` modulo DEPTH.
  - When `st_valid` is high and the buffer is full, the store is not taken; the upstream stage must hold it.
- **Match:** an entry matches a load when `entry.addr[AW-1:1] == ld_addr[AW-1:1]`.
- **Forward:** the youngest matching entry is a word store and the load is a word load. `ld_data` = that entry's data, and `memRead` = 0.
- **Hazard:** any matching entry exists but forwarding does not apply (byte store or byte load involved). `ld_stall` = 1.
- **Port arbitration, per cycle, in priority order:**
  1. `ld_valid && !hazard && !forward`: `memRead` = 1, `addr` = `ld_addr`, `sByte` = `ld_byte`, `ld_data` = `mem_rdata`. No drain.
  2. Otherwise, if `!empty`: `memWrite` = 1, and `addr`, `wrData` and `sByte` come from the `head` entry. `head` pops at the clock edge.
  3. Otherwise the port is idle: all enables 0, and `addr`/`wrData` = 0.
- **Hazard resolution:** during a hazard, drains proceed under rule 2 until no match remains. The stall then drops, so there is no deadlock.
- **Store and load in the same cycle:** the load is treated as older. It does not see the incoming store.
- **Count update:** push and pop in the same cycle leave `count` unchanged. Pointers wrap at DEPTH.
- **Arithmetic:** pointers are log2(DEPTH) bits with natural wrap. `count` ranges 0..DEPTH. Full = (`count` == DEPTH).

## Timing
- **Reset values:** `head`, `tail` and `count` = 0. Outputs after reset: `st_ready` = 1, `empty` = 1, `count` = 0, `memWrite` = 0, `memRead` = 0, `ld_stall` = 0, `addr` = 0, `wrData` = 0, `ld_data` = 0.
- **Reset mid-operation:** asserting `rst` discards all buffered stores immediately.
- **Push latency:** a pushed store is forwardable and drainable from the next cycle. It is never drained in the cycle it is pushed.
- **Drain timing:** `dataMemory` writes on the same rising edge at which `head` pops.
- **Load latency:** 0 cycles when served from memory or forwarded. The stall lasts while any matching entry remains.
- **Combinational outputs:** all `dataMemory` outputs, `ld_data` and `ld_stall` are combinational from registered state plus the `ld_*` inputs. `st_ready`, `empty` and `count` are functions of registered state only.
- **Full plus drain:** with the buffer full, `st_ready` = 0 even if a drain occurs that cycle. The store is accepted one cycle later.

## Test plan
1. **Reset:** assert `rst` mid-run with 3 entries buffered. Required: `count` = 0, `empty` = 1 and `memWrite` = 0 immediately, and no later writes of the discarded data.
2. **Drain order:** push word stores 0x0000←0x0FFF and 0x0002←0x22AA, with no loads. Required: `memWrite` is high for 2 cycles with `addr` 0x0000 then 0x0002, and `empty` = 1 afterwards.
3. **Full:** push 5 stores back-to-back with `ld_valid` held high to addresses 0x0100.. so that drains are blocked. Required: `st_ready` = 0 after 4 pushes, and the 5th is accepted one cycle after the first drain.
4. **Forwarding:** buffer word stores 0x0004←0x1111 then 0x0004←0x2222, then issue a word load from 0x0004. Required: `ld_data` = 0x2222, `memRead` = 0, `ld_stall` = 0.
5. **Hazard:** buffer a byte store 0x0002←0xAA, then issue a word load from 0x0002. Required: `ld_stall` = 1 for exactly 1 cycle while the entry drains. The next cycle has `memRead` = 1 and `ld_data` = `mem_rdata`.
6. **Load priority:** with 2 entries buffered, hold a non-matching load for 3 cycles. Required: `memWrite` = 0 and `count` = 2 throughout, and draining resumes when `ld_valid` drops.

Source files
------------

// File: rtl/store_buffer.sv
// Four-entry store buffer between EX/MEM and dataMemory: buffers stores, drains them when the
// memory port is free, forwards word data to word loads and stalls loads on partial overlaps.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 16,
  parameter int unsigned DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic                     st_byte,
  output logic                     st_ready,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  input  logic                     ld_byte,
  output logic [DW-1:0]            ld_data,
  output logic                     ld_stall,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     memWrite,
  output logic                     memRead,
  output logic                     sByte,
  output logic [AW-1:0]            addr,
  output logic [DW-1:0]            wrData,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]    addrQ [DEPTH];
  logic [DW-1:0]    dataQ [DEPTH];
  logic [DEPTH-1:0] byteQ;

  logic [PW-1:0] headQ, headD;
  logic [PW-1:0] tailQ, tailD;
  logic [CW-1:0] countQ, countD;

  logic          full;
  logic          push;
  logic          pop;
  logic          anyMatch;
  logic [PW-1:0] matchIdx;
  logic [PW-1:0] idx;
  logic          forward;
  logic          hazard;
  logic          memLoad;

  assign full     = (countQ == CW'(DEPTH));
  assign empty    = (countQ == '0);
  assign st_ready = !full;
  assign count    = countQ;

  // Walk oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    anyMatch = 1'b0;
    matchIdx = '0;
    idx      = '0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      idx = headQ + PW'(k);
      if ((CW'(k) < countQ) && (addrQ[idx][AW-1:1] == ld_addr[AW-1:1])) begin
        anyMatch = 1'b1;
        matchIdx = idx;
      end
    end
  end

  assign forward = ld_valid && anyMatch && !byteQ[matchIdx] && !ld_byte;
  assign hazard  = ld_valid && anyMatch && !forward;
  assign memLoad = ld_valid && !anyMatch;
  assign push    = st_valid && !full;
  // Forwarded and stalled loads leave the port free, so the head keeps draining.
  assign pop     = !empty && !memLoad;

  always_comb begin
    memWrite = 1'b0;
    memRead  = 1'b0;
    sByte    = 1'b0;
    addr     = '0;
    wrData   = '0;
    ld_data  = '0;
    ld_stall = hazard;
    if (memLoad) begin
      memRead = 1'b1;
      addr    = ld_addr;
      sByte   = ld_byte;
      ld_data = mem_rdata;
    end else if (pop) begin
      memWrite = 1'b1;
      addr     = addrQ[headQ];
      wrData   = dataQ[headQ];
      sByte    = byteQ[headQ];
    end
    if (forward) begin
      ld_data = dataQ[matchIdx];
    end
  end

  always_comb begin
    headD  = pop  ? headQ + PW'(1) : headQ;
    tailD  = push ? tailQ + PW'(1) : tailQ;
    countD = countQ;
    unique case ({push, pop})
      2'b10:   countD = countQ + CW'(1);
      2'b01:   countD = countQ - CW'(1);
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
    end else begin
      headQ  <= headD;
      tailQ  <= tailD;
      countQ <= countD;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addrQ[tailQ] <= st_addr;
      dataQ[tailQ] <= st_data;
      byteQ[tailQ] <= st_byte;
    end
  end

endmodule
